// File: rtl/stq_adata_mp.sv
// Store-queue address-data array: DEPTH entries of DW data plus a valid bit,
// NWR write ports, NRD read ports, range flush, live valid-entry count.
//
// Ports:
//   clk, rst (sync, active-low)
//   wrt_en/wrt_WQ/wrt_adata  : per-port write enable, index, data
//   upd_WQ                   : per-port read index
//   upd_adata/upd_vld        : per-port read data and valid
//   flush_en/flush_lo/_hi    : inclusive (possibly wrapping) invalidate range
//   vld_cnt/full             : registered valid-entry count and full flag
module stq_adata_mp #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DW    = 5,
    parameter int NWR   = 2,
    parameter int NRD   = 2,
    parameter int RDREG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    wrt_en,
    input  logic [NWR*AW-1:0] wrt_WQ,
    input  logic [NWR*DW-1:0] wrt_adata,
    input  logic [NRD*AW-1:0] upd_WQ,
    output logic [NRD*DW-1:0] upd_adata,
    output logic [NRD-1:0]    upd_vld,
    input  logic              flush_en,
    input  logic [AW-1:0]     flush_lo,
    input  logic [AW-1:0]     flush_hi,
    output logic [AW:0]       vld_cnt,
    output logic              full
);

    logic [DW-1:0]    data_q [DEPTH];
    logic [DW-1:0]    data_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;
    logic             full_q;
    logic             full_d;

    // lo > hi describes a range that wraps past the top index
    function automatic logic in_rng(input logic [AW-1:0] i,
                                    input logic [AW-1:0] lo,
                                    input logic [AW-1:0] hi);
        if (lo <= hi)
            return (i >= lo) && (i <= hi);
        else
            return (i >= lo) || (i <= hi);
    endfunction

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (flush_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (in_rng(i[AW-1:0], flush_lo, flush_hi))
                    vld_d[i] = 1'b0;
            end
        end
        // Writes follow the flush so they win; walk ports high to low so
        // the lowest-numbered port is the last assignment on a collision.
        for (int p = NWR - 1; p >= 0; p--) begin
            if (wrt_en[p]) begin
                data_d[wrt_WQ[p*AW +: AW]] = wrt_adata[p*DW +: DW];
                vld_d[wrt_WQ[p*AW +: AW]]  = 1'b1;
            end
        end
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++)
            cnt_d = cnt_d + {{AW{1'b0}}, vld_d[i]};
        full_d = (cnt_d == (AW+1)'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                data_q[i] <= '0;
            vld_q  <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                data_q[i] <= data_d[i];
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    assign vld_cnt = cnt_q;
    assign full    = full_q;

    generate
        if (RDREG == 0) begin : g_rd_comb
            // Reads see pre-edge state; no bypass of same-cycle writes
            always_comb begin
                upd_adata = '0;
                upd_vld   = '0;
                for (int r = 0; r < NRD; r++) begin
                    upd_adata[r*DW +: DW] = data_q[upd_WQ[r*AW +: AW]];
                    upd_vld[r]            = vld_q[upd_WQ[r*AW +: AW]];
                end
            end
        end else begin : g_rd_reg
            logic [NRD*DW-1:0] rdat_q;
            logic [NRD*DW-1:0] rdat_d;
            logic [NRD-1:0]    rvld_q;
            logic [NRD-1:0]    rvld_d;

            // Capture post-update entry state (write-first)
            always_comb begin
                rdat_d = '0;
                rvld_d = '0;
                for (int r = 0; r < NRD; r++) begin
                    rdat_d[r*DW +: DW] = data_d[upd_WQ[r*AW +: AW]];
                    rvld_d[r]          = vld_d[upd_WQ[r*AW +: AW]];
                end
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    rdat_q <= '0;
                    rvld_q <= '0;
                end else begin
                    rdat_q <= rdat_d;
                    rvld_q <= rvld_d;
                end
            end

            assign upd_adata = rdat_q;
            assign upd_vld   = rvld_q;
        end
    endgenerate

endmodule
